imem_responder: RTL and testbench

Instruction-memory responder that serves the core's fetch port. It accepts one word-aligned fetch address at a time over a valid/ready request channel. After a programmable number of wait states it returns the 32-bit instruction over a valid/ready response channel. A side load port lets the bench or a boot loader write program words into the backing array.

---
 rtl/imem_responder_if.sv | 28 ++
 rtl/imem_responder.sv | 137 +++++++++++++
 tb/tb_imem_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
//------------------------------------------------------------------------------
// Module      : imem_responder_if
// Description : Fetch request/response channel between core and imem_responder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

`default_nettype wire

// File: rtl/imem_responder.sv
//------------------------------------------------------------------------------
// Module      : imem_responder
// Description : Single-outstanding instruction fetch responder with wait states.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    localparam int         IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    imem_responder_if.slave       bus,
    input  wire logic             load_en,
    input  wire logic [IDX_W-1:0] load_idx,
    input  wire logic [31:0]      load_data,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0]  C_WS      = 4'(WAIT_STATES);
    localparam logic [32:0] C_BASE33  = {1'b0, BASE_ADDR};
    localparam logic [32:0] C_LIMIT33 = C_BASE33 + (33'(DEPTH_WORDS) << 2);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic        err_q;
    logic [31:0] instr_q;
    logic        rsp_err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_enter_resp;
    logic [32:0] w_addr33;
    logic        w_req_err;
    logic [31:0] w_fetch_addr;
    logic        w_fetch_err;
    logic [31:0] w_offset;
    logic [31:0] w_rd_word;
    logic        w_unused_offset_bits;

    // Range checks are done one bit wider so addresses near 0xFFFF_FFFF cannot wrap.
    assign w_addr33  = {1'b0, bus.req_addr};
    assign w_req_err = (bus.req_addr[1:0] != 2'b00) ||
                       (w_addr33 < C_BASE33) ||
                       (w_addr33 >= C_LIMIT33);
    assign w_accept  = (state_q == ST_IDLE) && bus.req_valid;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        w_enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    if (C_WS == 4'd0) begin
                        state_d      = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = C_WS;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d      = ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With zero wait states RESP is entered on the accept edge, before addr_q holds the address.
    assign w_fetch_addr = (state_q == ST_IDLE) ? bus.req_addr : addr_q;
    assign w_fetch_err  = (state_q == ST_IDLE) ? w_req_err    : err_q;
    assign w_offset     = w_fetch_addr - BASE_ADDR;
    assign w_rd_word    = mem[w_offset[IDX_W+1:2]];
    assign w_unused_offset_bits = ^{w_offset[31:IDX_W+2], w_offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'd0;
            err_q     <= 1'b0;
            instr_q   <= NOP_INSTR;
            rsp_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                addr_q <= bus.req_addr;
                err_q  <= w_req_err;
            end
            if (w_enter_resp) begin
                instr_q   <= w_fetch_err ? NOP_INSTR : w_rd_word;
                rsp_err_q <= w_fetch_err;
            end
        end
    end

    // Backing store is deliberately unreset so a boot image survives rst.
    always_ff @(posedge clk) begin
        if (load_en && (32'(load_idx) < 32'(DEPTH_WORDS))) begin
            mem[load_idx] <= load_data;
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_instr = instr_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
//------------------------------------------------------------------------------
// Module      : tb_imem_responder
// Description : Directed bench for imem_responder at 0, 1 and 15 wait states.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_responder;

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [9:0]  load_idx = 10'd0;
    logic [31:0] load_data = 32'd0;
    logic        busy0, busy1, busy15;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    imem_responder_if bus0 ();
    imem_responder_if bus1 ();
    imem_responder_if bus15 ();

    imem_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .busy(busy0)
    );
    imem_responder #(.WAIT_STATES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .busy(busy1)
    );
    imem_responder #(.WAIT_STATES(15)) u_dut15 (
        .clk(clk), .rst(rst), .bus(bus15.slave),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data), .busy(busy15)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic get_valid(input int s);
        case (s)
            0:       return bus0.rsp_valid;
            1:       return bus1.rsp_valid;
            default: return bus15.rsp_valid;
        endcase
    endfunction

    function automatic logic get_ready(input int s);
        case (s)
            0:       return bus0.req_ready;
            1:       return bus1.req_ready;
            default: return bus15.req_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0:       return busy0;
            1:       return busy1;
            default: return busy15;
        endcase
    endfunction

    function automatic logic [31:0] get_instr(input int s);
        case (s)
            0:       return bus0.rsp_instr;
            1:       return bus1.rsp_instr;
            default: return bus15.rsp_instr;
        endcase
    endfunction

    function automatic logic get_err(input int s);
        case (s)
            0:       return bus0.rsp_err;
            1:       return bus1.rsp_err;
            default: return bus15.rsp_err;
        endcase
    endfunction

    task automatic drive(input int s, input logic v, input logic [31:0] a, input logic r);
        case (s)
            0:       begin bus0.req_valid = v;  bus0.req_addr = a;  bus0.rsp_ready = r;  end
            1:       begin bus1.req_valid = v;  bus1.req_addr = a;  bus1.rsp_ready = r;  end
            default: begin bus15.req_valid = v; bus15.req_addr = a; bus15.rsp_ready = r; end
        endcase
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = idx[9:0];
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Latency counts the accept edge as cycle 1: rsp_valid seen right after it gives 1.
    task automatic fetch(input int s, input logic [31:0] a, input logic [31:0] exp_i,
                         input logic exp_e, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        drive(s, 1'b1, a, 1'b1);
        check({tag, "/req_ready_idle"}, 32'(get_ready(s)), 32'd1);
        @(posedge clk);
        @(negedge clk);
        drive(s, 1'b0, a, 1'b1);
        lat = 1;
        while (!get_valid(s) && lat < 40) begin
            check({tag, "/ready_while_busy"}, 32'(get_ready(s) & get_busy(s)), 32'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/instr"}, get_instr(s), exp_i);
        check({tag, "/err"}, 32'(get_err(s)), 32'(exp_e));
        check({tag, "/ready_in_resp"}, 32'(get_ready(s)), 32'd0);
        @(negedge clk);
        check({tag, "/valid_after_hs"}, 32'(get_valid(s)), 32'd0);
        check({tag, "/ready_after_hs"}, 32'(get_ready(s)), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int hs;
        int lat;
        drive(0, 1'b0, 32'd0, 1'b1);
        drive(1, 1'b0, 32'd0, 1'b1);
        drive(2, 1'b0, 32'd0, 1'b1);

        repeat (2) @(negedge clk);
        check("reset/req_ready", 32'(bus1.req_ready), 32'd1);
        check("reset/rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("reset/rsp_instr", bus1.rsp_instr, C_NOP);
        check("reset/rsp_err", 32'(bus1.rsp_err), 32'd0);
        check("reset/busy", 32'(busy1), 32'd0);
        rst = 1'b0;

        load(0, 32'h0010_0093);
        load(1, 32'h0020_0113);
        load(2, 32'h1234_5678);
        load(3, 32'h5555_5555);

        fetch(1, 32'h0000_0000, 32'h0010_0093, 1'b0, 2, "ws1_addr0");
        fetch(1, 32'h0000_0004, 32'h0020_0113, 1'b0, 2, "ws1_addr4");
        fetch(1, 32'h0000_0002, C_NOP, 1'b1, 2, "misaligned");
        fetch(1, 32'h0000_1000, C_NOP, 1'b1, 2, "past_end");
        fetch(1, 32'hFFFF_FFFC, C_NOP, 1'b1, 2, "top_no_wrap");

        // Backpressure: response held for 5 cycles with rsp_ready low.
        @(negedge clk);
        drive(1, 1'b1, 32'h4, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 32'h4, 1'b0);
        lat = 0;
        while (!bus1.rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp/valid", 32'(bus1.rsp_valid), 32'd1);
            check("bp/instr", bus1.rsp_instr, 32'h0020_0113);
            check("bp/ready", 32'(bus1.req_ready), 32'd0);
            @(negedge clk);
        end
        drive(1, 1'b0, 32'h4, 1'b1);
        @(negedge clk);
        check("bp/valid_released", 32'(bus1.rsp_valid), 32'd0);
        check("bp/ready_released", 32'(bus1.req_ready), 32'd1);

        // Reset while waiting on address 0x8.
        @(negedge clk);
        drive(1, 1'b1, 32'h8, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 32'h8, 1'b1);
        check("rst_wait/busy_before", 32'(busy1), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_wait/valid", 32'(bus1.rsp_valid), 32'd0);
        check("rst_wait/busy", 32'(busy1), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_wait/no_stale", 32'(bus1.rsp_valid), 32'd0);
        end
        fetch(1, 32'h0000_0008, 32'h1234_5678, 1'b0, 2, "after_rst");

        // Load to word 3 on the very edge that enters RESP for 0xC.
        @(negedge clk);
        drive(1, 1'b1, 32'hC, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 32'hC, 1'b1);
        load_en   = 1'b1;
        load_idx  = 10'd3;
        load_data = 32'hAAAA_AAAA;
        @(posedge clk);
        @(negedge clk);
        load_en = 1'b0;
        check("raw/valid", 32'(bus1.rsp_valid), 32'd1);
        check("raw/old_word", bus1.rsp_instr, 32'h5555_5555);
        @(negedge clk);
        fetch(1, 32'h0000_000C, 32'hAAAA_AAAA, 1'b0, 2, "raw_repeat");

        fetch(0, 32'h0000_0000, 32'h0010_0093, 1'b0, 1, "ws0_addr0");
        fetch(0, 32'h0000_0004, 32'h0020_0113, 1'b0, 1, "ws0_addr4");
        fetch(2, 32'h0000_0004, 32'h0020_0113, 1'b0, 16, "ws15_addr4");
        fetch(2, 32'hFFFF_FFFC, C_NOP, 1'b1, 16, "ws15_err");

        // Back-to-back with zero wait states: one fetch every two edges.
        @(negedge clk);
        drive(0, 1'b1, 32'h4, 1'b1);
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b2b/ready_while_busy", 32'(bus0.req_ready & busy0), 32'd0);
            if (bus0.rsp_valid) begin
                hs++;
                check("b2b/instr", bus0.rsp_instr, 32'h0020_0113);
            end
        end
        drive(0, 1'b0, 32'h4, 1'b1);
        check("b2b/handshakes", 32'(hs), 32'd4);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
